axis_word_to_byte: RTL and testbench
====================================

Name: axis_word_to_byte

Overview:
- Transmit-side stream serializer.
- Accepts T_DATA_WIDTH-bit AXI-stream words with keep/last, typically drained from the UDP payload FIFO.
- Emits an 8-bit byte stream with last toward the MAC transmit path.
- Also reports the byte length of each completed frame.

Parameters:
T_DATA_WIDTH, 32, input word width; must be a multiple of 8 and at least 16
KEEP_WIDTH, T_DATA_WIDTH/8, derived; byte lanes per word
LEN_WIDTH, 16, width of frame length counter/output

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
s_data_i  input  T_DATA_WIDTH  input word; byte lane k = bits [8k+7:8k]
s_keep_i  input  KEEP_WIDTH  per-lane valid bits
s_last_i  input  1  final word of frame
s_valid_i  input  1  input valid
s_ready_o  output  1  input ready
m_data_o  output  8  output byte
m_last_o  output  1  final byte of frame
m_valid_o  output  1  output valid
m_ready_i  input  1  output ready
frame_len_o  output  LEN_WIDTH  byte count of last completed frame
frame_done_o  output  1  one-cycle pulse when a frame's last byte is accepted

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values:
  - m_valid_o=0, m_last_o=0, frame_done_o=0, frame_len_o=0.
  - Internal word, mask and last registers cleared; byte counter=0.
  - s_ready_o=1 once reset is released.
- Holding register: word_q, mask_q (KEEP_WIDTH), last_q, full_q.
  - m_valid_o = full_q.
  - m_data_o = lane of word_q selected by the lowest set bit of mask_q.
  - m_last_o = last_q AND mask_q has exactly one bit set.
- Input acceptance:
  - s_ready_o = !full_q OR (m_ready_i AND mask_q has exactly one bit set).
  - This is a combinational path m_ready_i->s_ready_o; it allows back-to-back words with no bubble.
- On a byte handshake (m_valid_o & m_ready_i): clear the lowest set bit of mask_q; if mask_q becomes zero, full_q clears.
- On an input handshake (s_valid_i & s_ready_o) with s_keep_i != 0: load word_q, mask_q<=s_keep_i, last_q<=s_last_i, full_q<=1.
  - The first byte is presented the cycle after acceptance (latency 1).
  - A simultaneous last-byte handshake and load: the load wins; full_q stays 1.
- Sparse keep: lanes with keep=0 are skipped; bytes are emitted in ascending lane order. Non-contiguous keep is legal.
- keep==0 beat: accepted in one cycle, produces no output, state unchanged. A last flag on such a beat is discarded; upstream must not send it.
- Throughput: 1 byte/cycle sustained when m_ready_i=1 and the source keeps pace.
- Frame counter:
  - Increments on every byte handshake and saturates at all-ones.
  - On the handshake with m_last_o=1: frame_len_o <= counter+1 (saturated), frame_done_o pulses 1 cycle, counter <= 0.
  - frame_len_o holds its value until the next frame completes.
- Output stability: while m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o are held stable and no input is accepted.
- Reset mid-frame: all state drops immediately; the partial frame is lost and produces no frame_done_o.

Decomposition:
- Shared stream package: KEEP_WIDTH derivation function; a lowest-set-bit function returning a lane index and a one-hot clear mask; a single-bit-set check.
- One natural sub-module: axis_byte_lane_select. Combinational; takes mask, returns the lane index, the next mask and the is_last_lane flag.
- Everything else lives in the top module.

Test Plan:
- Reset, then one word 0x44332211, keep=4'hF, last=1, m_ready_i=1 -> bytes 11,22,33,44 on 4 consecutive cycles; m_last_o only on 44; frame_done_o pulse with frame_len_o=4.
- Two words 0x44332211 (keep F, last 0) then 0x00006655 (keep 3, last 1), m_ready_i=1 -> 11,22,33,44,55,66 with no bubble; s_ready_o high on the 44 cycle; frame_len_o=6.
- Sparse keep 4'b1010 on 0xDDCCBBAA, last=1 -> bytes BB then DD (last on DD); frame_len_o=2.
- m_ready_i toggling 1,0,0,1 during a frame -> m_data_o stable while stalled; s_ready_o=0 while a byte is pending; no byte duplicated or lost.
- keep=0 beat inserted between frames -> accepted in 1 cycle, no output, frame counts unaffected.
- Assert reset after 2 bytes of a 4-byte frame -> m_valid_o=0 the same cycle, no frame_done_o; the next frame 0x04030201 yields frame_len_o=4.

Source files
------------

// File: rtl/axis_word_to_byte_pkg.sv
// Shared stream helpers for the word-to-byte serializer: lane-count derivation,
// lowest-set-lane search and single-lane detection.
package axis_word_to_byte_pkg;

    localparam int MAX_LANES  = 64;
    localparam int LANE_IDX_W = 6;

    typedef logic [MAX_LANES-1:0] lane_mask_t;

    typedef struct packed {
        logic [LANE_IDX_W-1:0] idx;
        lane_mask_t            onehot;
    } lowest_lane_t;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic lowest_lane_t lowest_lane(input lane_mask_t mask);
        lowest_lane_t r;
        r.idx    = '0;
        r.onehot = mask & (~mask + 1'b1);
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (mask[i]) r.idx = LANE_IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic single_bit(input lane_mask_t mask);
        return (mask != '0) && ((mask & (mask - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/axis_byte_lane_select.sv
// Picks the next byte lane to emit from a keep mask and computes the mask
// that remains once that lane has been sent.
module axis_byte_lane_select
    import axis_word_to_byte_pkg::*;
#(
    parameter int KEEP_WIDTH = 4,
    localparam int IDX_W     = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1
) (
    input  logic [KEEP_WIDTH-1:0] mask,
    output logic [IDX_W-1:0]      lane_idx,
    output logic [KEEP_WIDTH-1:0] next_mask,
    output logic                  is_last_lane
);

    lane_mask_t   mask_ext;
    lowest_lane_t low;
    logic         unused_bits;

    always_comb begin
        mask_ext     = lane_mask_t'(mask);
        low          = lowest_lane(mask_ext);
        lane_idx     = low.idx[IDX_W-1:0];
        next_mask    = mask & ~low.onehot[KEEP_WIDTH-1:0];
        is_last_lane = single_bit(mask_ext);
        unused_bits  = ^{low.idx, low.onehot};
    end

endmodule

// File: rtl/axis_word_to_byte.sv
// Serializes keep-qualified AXI-stream words into a byte stream and reports
// the byte length of every completed frame.
module axis_word_to_byte
    import axis_word_to_byte_pkg::*;
#(
    parameter int T_DATA_WIDTH = 32,
    parameter int KEEP_WIDTH   = keep_width(T_DATA_WIDTH),
    parameter int LEN_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic [KEEP_WIDTH-1:0]   s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [7:0]              m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [LEN_WIDTH-1:0]    frame_len_o,
    output logic                    frame_done_o
);

    localparam int IDX_W = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

    logic [T_DATA_WIDTH-1:0] word_q;
    logic [KEEP_WIDTH-1:0]   mask_q;
    logic                    last_q;
    logic                    full_q;
    logic [LEN_WIDTH-1:0]    byte_cnt_q;

    logic [IDX_W-1:0]        lane_idx;
    logic [KEEP_WIDTH-1:0]   next_mask;
    logic                    is_last_lane;
    logic                    byte_hs;
    logic                    load;
    logic [LEN_WIDTH-1:0]    cnt_inc;

    axis_byte_lane_select #(
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_lane_select (
        .mask         (mask_q),
        .lane_idx     (lane_idx),
        .next_mask    (next_mask),
        .is_last_lane (is_last_lane)
    );

    // A new word may enter while the final lane of the current one is leaving,
    // which is what keeps back-to-back words bubble-free.
    assign s_ready_o = !full_q || (m_ready_i && is_last_lane);
    assign m_valid_o = full_q;
    assign m_last_o  = last_q && is_last_lane;
    assign byte_hs   = full_q && m_ready_i;
    assign load      = s_valid_i && s_ready_o && (s_keep_i != '0);
    assign cnt_inc   = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 1'b1;

    always_comb begin
        m_data_o = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (int'(lane_idx) == i) m_data_o = word_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q       <= '0;
            mask_q       <= '0;
            last_q       <= 1'b0;
            full_q       <= 1'b0;
            byte_cnt_q   <= '0;
            frame_len_o  <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            if (byte_hs) begin
                mask_q <= next_mask;
                if (next_mask == '0) full_q <= 1'b0;
                if (m_last_o) begin
                    frame_len_o  <= cnt_inc;
                    frame_done_o <= 1'b1;
                    byte_cnt_q   <= '0;
                end else begin
                    byte_cnt_q   <= cnt_inc;
                end
            end
            // Load after the byte update so a new word overrides the drained mask.
            if (load) begin
                word_q <= s_data_i;
                mask_q <= s_keep_i;
                last_q <= s_last_i;
                full_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_word_to_byte.sv
// Directed bench for axis_word_to_byte: table of single-word frames plus
// hand-written multi-cycle sequences (back-to-back, stall, empty beat, reset).
module tb_axis_word_to_byte;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_data_i;
    logic [3:0]  s_keep_i;
    logic        s_last_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [7:0]  m_data_o;
    logic        m_last_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [15:0] frame_len_o;
    logic        frame_done_o;

    axis_word_to_byte #(
        .T_DATA_WIDTH (32),
        .LEN_WIDTH    (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_i     (s_data_i),
        .s_keep_i     (s_keep_i),
        .s_last_i     (s_last_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .m_data_o     (m_data_o),
        .m_last_o     (m_last_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .frame_len_o  (frame_len_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         cyc;
    } byte_rec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [31:0] exp_bytes;
        int          exp_n;
    } vec_t;

    byte_rec_t bq[$];
    int        dq[$];
    int        cyc = 0;
    int        n_pass = 0;
    int        n_total = 0;
    logic [7:0] acc_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid_o && m_ready_i) bq.push_back('{d: m_data_o, l: m_last_o, cyc: cyc});
            if (frame_done_o) dq.push_back(int'(frame_len_o));
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l,
                             output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        s_data_i = d; s_keep_i = k; s_last_i = l; s_valid_i = 1'b1;
        while (!acc && waited < 50) begin
            @(negedge clk);
            if (s_ready_o) begin
                acc = 1'b1;
                acc_data = m_data_o;
            end
            @(posedge clk); #1;
            waited++;
        end
        s_valid_i = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic check_frame(input string name, input logic [63:0] exp_bytes,
                               input int n, input int exp_len, input bit contig);
        int w;
        int m;
        w = 0;
        while (dq.size() == 0 && w < 100) begin
            @(posedge clk); #2;
            w++;
        end
        if (dq.size() == 0) begin
            chk({name, "_done_timeout"}, 0, 1);
        end else begin
            chk({name, "_nbytes"}, bq.size(), n);
            m = (bq.size() < n) ? bq.size() : n;
            for (int i = 0; i < m; i++) begin
                chk($sformatf("%s_byte%0d", name, i), bq[i].d, exp_bytes[8*i +: 8]);
                chk($sformatf("%s_last%0d", name, i), bq[i].l, (i == n - 1));
            end
            if (contig && m == n) chk({name, "_nobubble"}, bq[n-1].cyc - bq[0].cyc, n - 1);
            chk({name, "_len"}, dq[0], exp_len);
            chk({name, "_len_port"}, frame_len_o, exp_len);
        end
        bq.delete();
        dq.delete();
    endtask

    vec_t vecs[6];
    int   waited;
    int   w;

    initial begin
        vecs[0] = '{data: 32'h44332211, keep: 4'hF, exp_bytes: 32'h44332211, exp_n: 4};
        vecs[1] = '{data: 32'hDDCCBBAA, keep: 4'hA, exp_bytes: 32'h0000DDBB, exp_n: 2};
        vecs[2] = '{data: 32'h000000EE, keep: 4'h1, exp_bytes: 32'h000000EE, exp_n: 1};
        vecs[3] = '{data: 32'h87654321, keep: 4'h9, exp_bytes: 32'h00008721, exp_n: 2};
        vecs[4] = '{data: 32'h0000AB00, keep: 4'h6, exp_bytes: 32'h000000AB, exp_n: 2};
        vecs[5] = '{data: 32'h5A000000, keep: 4'h8, exp_bytes: 32'h0000005A, exp_n: 1};

        reset = 1'b1; s_data_i = '0; s_keep_i = '0; s_last_i = 1'b0;
        s_valid_i = 1'b0; m_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid_o, 0);
        chk("rst_m_last", m_last_o, 0);
        chk("rst_frame_done", frame_done_o, 0);
        chk("rst_frame_len", frame_len_o, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", s_ready_o, 1);
        @(posedge clk); #1;

        // Single-word frames with a free-running sink.
        for (int v = 0; v < 6; v++) begin
            send_word(vecs[v].data, vecs[v].keep, 1'b1, waited);
            @(negedge clk);
            chk($sformatf("vec%0d_lat1_valid", v), m_valid_o, 1);
            chk($sformatf("vec%0d_lat1_data", v), m_data_o, vecs[v].exp_bytes[7:0]);
            check_frame($sformatf("vec%0d", v), {32'h0, vecs[v].exp_bytes},
                        vecs[v].exp_n, vecs[v].exp_n, 1'b1);
            @(posedge clk); #1;
        end

        // Two words of one frame, back to back.
        send_word(32'h44332211, 4'hF, 1'b0, waited);
        send_word(32'h00006655, 4'h3, 1'b1, waited);
        chk("b2b_ready_on_44", acc_data, 8'h44);
        chk("b2b_wait", waited, 4);
        check_frame("b2b", 64'h0000_6655_4433_2211, 6, 6, 1'b1);
        @(posedge clk); #1;

        // Sink stalls for two cycles after the first byte.
        send_word(32'h44332211, 4'hF, 1'b1, waited);
        s_data_i = 32'hCAFEF00D; s_keep_i = 4'hF; s_last_i = 1'b1; s_valid_i = 1'b1;
        @(posedge clk); #1;
        m_ready_i = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_data", s), m_data_o, 8'h22);
            chk($sformatf("stall%0d_valid", s), m_valid_o, 1);
            chk($sformatf("stall%0d_s_ready", s), s_ready_o, 0);
            @(posedge clk); #1;
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        check_frame("stall", 64'h44332211, 4, 4, 1'b0);
        @(posedge clk); #1;

        // Empty-keep beat between frames.
        send_word(32'hFFFFFFFF, 4'h0, 1'b0, waited);
        chk("keep0_one_cycle", waited, 1);
        repeat (3) begin
            @(negedge clk);
            chk("keep0_no_valid", m_valid_o, 0);
        end
        chk("keep0_no_bytes", bq.size(), 0);
        chk("keep0_no_done", dq.size(), 0);
        chk("keep0_len_held", frame_len_o, 4);
        @(posedge clk); #1;
        send_word(32'h00000077, 4'h1, 1'b1, waited);
        check_frame("after_keep0", 64'h77, 1, 1, 1'b1);
        @(posedge clk); #1;

        // Reset after two bytes of a four-byte frame.
        send_word(32'hD4C3B2A1, 4'hF, 1'b1, waited);
        w = 0;
        while (bq.size() < 2 && w < 50) begin
            @(posedge clk); #2;
            w++;
        end
        chk("midrst_two_bytes", bq.size(), 2);
        reset = 1'b1;
        #1;
        chk("midrst_valid_drop", m_valid_o, 0);
        chk("midrst_no_done", frame_done_o, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_done_q", dq.size(), 0);
        chk("midrst_len_cleared", frame_len_o, 0);
        chk("midrst_idle", m_valid_o, 0);
        bq.delete();
        send_word(32'h04030201, 4'hF, 1'b1, waited);
        check_frame("post_rst", 64'h04030201, 4, 4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
